// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) used by the sync generator and the renderer.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Sync windows are half-open: [START, END)
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int unsigned CW = 10;

   function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/edge_strobe.sv
// Rising-edge detector: one-clk pulse per 0->1 transition of a level in the clk domain.
module edge_strobe (
   input  logic clk,
   input  logic rst_n,
   input  logic level_in,
   output logic pulse_out
);

   logic level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_in;
      end
   end

   // Gated by rst_n so no strobe escapes while the block is held in reset
   assign pulse_out = level_in & ~level_q & rst_n;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable strobe, h/v counters and registered sync/blank decode.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_pkg::V_BP,
   parameter int unsigned CW       = vga_pkg::CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          div_tap,
   output logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

   logic          pix_en_c;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   edge_strobe u_strobe (
      .clk       (clk),
      .rst_n     (rst_n),
      .level_in  (div_tap),
      .pulse_out (pix_en_c)
   );

   // Counter advance and decode of the post-update position, all on the same pix_en edge
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_en_c) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
         hsync_d       = ~vga_pkg::in_window(32'(x_d), H_SYNC_START, H_SYNC_END);
         vsync_d       = ~vga_pkg::in_window(32'(y_d), V_SYNC_START, V_SYNC_END);
         video_on_d    = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
         line_start_d  = (x_d == '0);
         frame_start_d = (x_d == '0) && (y_d == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_en      = pix_en_c;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
